// File: rtl/data_memory_arbiter_if.sv
// Purpose : one requester's link to the data memory arbiter (request, write data, ack, read response).
// Latency : ack is combinational in the grant cycle; rvalid/rdata/err arrive one cycle after ack.
// Backpressure: requester holds req/we/addr/wdata stable until ack; no backpressure on responses.
// Ports (signals): req, we, addr, wdata driven by the master; ack, rvalid, rdata, err driven by the arbiter.
interface data_memory_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  ack, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rvalid, rdata, err
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Purpose : round-robin, burst-bounded sharing of one single-port data memory between two masters.
// Latency : ack zero-wait in the grant cycle; read data/err registered, valid one cycle after ack.
// Backpressure: an ungranted master simply sees no ack and keeps its request held; responses are never stalled.
// Ports: clk, reset (sync, active-low); m0/m1 requester links (slave modport);
//        mem_addr/mem_wdata/mem_read/mem_write to the memory, mem_rdata combinational from it.
module data_memory_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int RAM_SIZE  = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    data_memory_arbiter_if.slave        m0,
    data_memory_arbiter_if.slave        m1,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic                        mem_read,
    output logic                        mem_write,
    input  logic [31:0]                 mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int              BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BEAT_MAX   = BW'(MAX_BURST);
    localparam logic [BW-1:0]   BEAT_ONE   = BW'(1);
    // One extra bit so the byte limit cannot wrap for large RAM_SIZE.
    localparam logic [32:0]     ADDR_LIMIT = 33'(4 * RAM_SIZE);

    state_t         state, state_nxt;
    logic           last_owner, last_owner_nxt;
    logic [BW-1:0]  beat, beat_nxt;
    logic           serve0, serve1;
    logic           ack0, ack1;
    logic           oor0, oor1;

    logic           rvalid0, rvalid1;
    logic           err0, err1;
    logic [31:0]    rdata0, rdata1;

    assign oor0 = ({1'b0, m0.addr} >= ADDR_LIMIT);
    assign oor1 = ({1'b0, m1.addr} >= ADDR_LIMIT);

    // Grant selection and next-state; beat saturates at BEAT_MAX so a lone
    // owner can keep streaming while the limit only bites under contention.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        beat_nxt       = beat;
        serve0         = 1'b0;
        serve1         = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not own last wins (last_owner resets to 1).
                if (m0.req && (!m1.req || last_owner)) begin
                    serve0         = 1'b1;
                    state_nxt      = OWN0;
                    last_owner_nxt = 1'b0;
                    beat_nxt       = BEAT_ONE;
                end else if (m1.req) begin
                    serve1         = 1'b1;
                    state_nxt      = OWN1;
                    last_owner_nxt = 1'b1;
                    beat_nxt       = BEAT_ONE;
                end
            end
            OWN0: begin
                if (m0.req && ((beat < BEAT_MAX) || !m1.req)) begin
                    serve0   = 1'b1;
                    beat_nxt = (beat < BEAT_MAX) ? beat + BEAT_ONE : beat;
                end else if (m1.req) begin
                    serve1         = 1'b1;
                    state_nxt      = OWN1;
                    last_owner_nxt = 1'b1;
                    beat_nxt       = BEAT_ONE;
                end else begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            end
            OWN1: begin
                if (m1.req && ((beat < BEAT_MAX) || !m0.req)) begin
                    serve1   = 1'b1;
                    beat_nxt = (beat < BEAT_MAX) ? beat + BEAT_ONE : beat;
                end else if (m0.req) begin
                    serve0         = 1'b1;
                    state_nxt      = OWN0;
                    last_owner_nxt = 1'b0;
                    beat_nxt       = BEAT_ONE;
                end else begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // Nothing is issued while reset is low, so a write pending then is dropped.
    assign ack0 = serve0 & reset;
    assign ack1 = serve1 & reset;

    // Memory pins; out-of-range accesses are acked but never reach the memory.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (ack0) begin
            mem_addr = m0.addr;
            if (m0.we) begin
                mem_wdata = m0.wdata;
                mem_write = !oor0;
            end else begin
                mem_read  = !oor0;
            end
        end else if (ack1) begin
            mem_addr = m1.addr;
            if (m1.we) begin
                mem_wdata = m1.wdata;
                mem_write = !oor1;
            end else begin
                mem_read  = !oor1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat       <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            beat       <= beat_nxt;
            rvalid0    <= ack0 && !m0.we;
            rvalid1    <= ack1 && !m1.we;
            err0       <= ack0 && oor0;
            err1       <= ack1 && oor1;
            // rdata only moves on a read completion; out-of-range reads return zero.
            if (ack0 && !m0.we) begin
                rdata0 <= oor0 ? 32'h0 : mem_rdata;
            end
            if (ack1 && !m1.we) begin
                rdata1 <= oor1 ? 32'h0 : mem_rdata;
            end
        end
    end

    assign m0.ack    = ack0;
    assign m0.rvalid = rvalid0;
    assign m0.rdata  = rdata0;
    assign m0.err    = err0;
    assign m1.ack    = ack1;
    assign m1.rvalid = rvalid1;
    assign m1.rdata  = rdata1;
    assign m1.err    = err1;

endmodule
